// File: rtl/cpu_control_seq.sv
// cpu_control_seq: fetch/execute T-state sequencer for the 8-bit CPU.
// Decodes the IR opcode into bus source, active-low load selects and PC/ALU controls.
module cpu_control_seq #(
  parameter int DATA_W = 8,
  parameter int OP_W   = 4
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              step_en_i,
  input  logic [DATA_W-1:0] ir_i,
  output logic [2:0]        bus_sel_o,
  output logic              ld_mar_n_o,
  output logic              ld_ir_n_o,
  output logic              ld_a_n_o,
  output logic              ld_b_n_o,
  output logic              ld_out_n_o,
  output logic              ram_we_n_o,
  output logic              pc_inc_o,
  output logic              pc_load_o,
  output logic              alu_sub_o,
  output logic              halted_o,
  output logic [2:0]        tstep_o,
  output logic              instr_done_o
);
  typedef enum logic [2:0] {T0, T1, T2, T3, T4} t_e;
  localparam logic [OP_W-1:0] OP_NOP = OP_W'(0), OP_LDA = OP_W'(1), OP_ADD = OP_W'(2),
                              OP_SUB = OP_W'(3), OP_STA = OP_W'(4), OP_LDI = OP_W'(5),
                              OP_JMP = OP_W'(6), OP_OUT = OP_W'(7), OP_HLT = OP_W'(15);
  t_e t_q, t_d;
  logic halted_q, halted_d;
  logic [OP_W-1:0] op;
  logic [2:0] bus;
  logic mar, irl, lda, ldb, ldo, we, inc, pcl, sub, done, active, nop, mem, arith;
  logic unused_operand;
  assign op             = ir_i[DATA_W-1 -: OP_W];
  assign unused_operand = ^ir_i[DATA_W-OP_W-1:0];
  assign nop            = op == OP_NOP || (op > OP_OUT && op != OP_HLT);
  assign arith          = op == OP_ADD || op == OP_SUB;
  assign mem            = op == OP_LDA || arith || op == OP_STA;
  assign active         = rst_n_i && step_en_i && !halted_q;
  always_comb begin
    bus = 3'd0; mar = 1'b0; irl = 1'b0; lda = 1'b0; ldb = 1'b0; ldo = 1'b0;
    we = 1'b0; inc = 1'b0; pcl = 1'b0; sub = 1'b0; done = 1'b0;
    case (t_q)
      T0: begin bus = 3'd1; mar = 1'b1; end
      T1: begin bus = 3'd2; irl = 1'b1; inc = 1'b1; done = nop; end
      T2: begin
        bus  = mem || op == OP_LDI || op == OP_JMP ? 3'd3 : op == OP_OUT ? 3'd4 : 3'd0;
        mar  = mem;
        lda  = op == OP_LDI;
        pcl  = op == OP_JMP;
        ldo  = op == OP_OUT;
        done = !mem;
      end
      T3: begin
        bus  = op == OP_STA ? 3'd4 : mem ? 3'd2 : 3'd0;
        lda  = op == OP_LDA;
        ldb  = arith;
        we   = op == OP_STA;
        done = !arith;
      end
      T4: begin bus = 3'd5; lda = 1'b1; sub = op == OP_SUB; done = 1'b1; end
      default: done = 1'b1;
    endcase
  end
  // Bus source keeps showing the decoded state while stalled or halted; only reset blanks it.
  assign bus_sel_o    = rst_n_i ? bus : 3'd0;
  assign ld_mar_n_o   = !(active && mar);
  assign ld_ir_n_o    = !(active && irl);
  assign ld_a_n_o     = !(active && lda);
  assign ld_b_n_o     = !(active && ldb);
  assign ld_out_n_o   = !(active && ldo);
  assign ram_we_n_o   = !(active && we);
  assign pc_inc_o     = active && inc;
  assign pc_load_o    = active && pcl;
  assign alu_sub_o    = active && sub;
  assign instr_done_o = active && done;
  assign halted_o     = halted_q;
  assign tstep_o      = t_q;
  assign t_d      = !rst_n_i ? T0 : !active ? t_q : done ? T0 : t_e'(t_q + 3'd1);
  assign halted_d = rst_n_i && (halted_q || (active && t_q == T2 && op == OP_HLT));
  always_ff @(posedge clk_i) begin
    t_q      <= t_d;
    halted_q <= halted_d;
  end
endmodule

// File: tb/tb_cpu_control_seq.sv
// tb_cpu_control_seq: randomized and directed scoreboard bench against a per-opcode microprogram model.
module tb_cpu_control_seq;
  typedef struct packed {
    logic [2:0] bus;
    logic mar_n, ir_n, a_n, b_n, out_n, we_n, inc, load, sub, halted, done;
    logic [2:0] t;
  } exp_t;
  logic clk = 1'b0, rst_n = 1'b0, step_en = 1'b0;
  logic [7:0] ir = 8'h00;
  logic [2:0] bus_sel, tstep;
  logic ld_mar_n, ld_ir_n, ld_a_n, ld_b_n, ld_out_n, ram_we_n, pc_inc, pc_load, alu_sub, halted, instr_done;
  exp_t q[$];
  int checks = 0, errors = 0;
  int mt = 0;
  bit mh = 1'b0;
  cpu_control_seq dut (
    .clk_i(clk), .rst_n_i(rst_n), .step_en_i(step_en), .ir_i(ir),
    .bus_sel_o(bus_sel), .ld_mar_n_o(ld_mar_n), .ld_ir_n_o(ld_ir_n), .ld_a_n_o(ld_a_n),
    .ld_b_n_o(ld_b_n), .ld_out_n_o(ld_out_n), .ram_we_n_o(ram_we_n), .pc_inc_o(pc_inc),
    .pc_load_o(pc_load), .alu_sub_o(alu_sub), .halted_o(halted), .tstep_o(tstep),
    .instr_done_o(instr_done)
  );
  always #5 clk = ~clk;
  function automatic int ilen(input logic [3:0] op);
    case (op)
      4'h1, 4'h4: return 4;
      4'h2, 4'h3: return 5;
      4'h5, 4'h6, 4'h7, 4'hF: return 3;
      default: return 2;
    endcase
  endfunction
  function automatic exp_t idle(input logic [2:0] b);
    exp_t e = '0;
    e.bus = b;
    {e.mar_n, e.ir_n, e.a_n, e.b_n, e.out_n, e.we_n} = 6'b111111;
    return e;
  endfunction
  // Microprogram step k of opcode op, ungated.
  function automatic exp_t micro(input logic [3:0] op, input int k);
    exp_t e = idle(3'd0);
    if (k == 0) begin e.bus = 3'd1; e.mar_n = 1'b0; end
    else if (k == 1) begin e.bus = 3'd2; e.ir_n = 1'b0; e.inc = 1'b1; end
    else case (op)
      4'h1: if (k == 2) begin e.bus = 3'd3; e.mar_n = 1'b0; end else begin e.bus = 3'd2; e.a_n = 1'b0; end
      4'h2, 4'h3:
        if (k == 2) begin e.bus = 3'd3; e.mar_n = 1'b0; end
        else if (k == 3) begin e.bus = 3'd2; e.b_n = 1'b0; end
        else begin e.bus = 3'd5; e.a_n = 1'b0; e.sub = (op == 4'h3); end
      4'h4: if (k == 2) begin e.bus = 3'd3; e.mar_n = 1'b0; end else begin e.bus = 3'd4; e.we_n = 1'b0; end
      4'h5: begin e.bus = 3'd3; e.a_n = 1'b0; end
      4'h6: begin e.bus = 3'd3; e.load = 1'b1; end
      4'h7: begin e.bus = 3'd4; e.out_n = 1'b0; end
      default: ;
    endcase
    e.done = (k == ilen(op) - 1);
    return e;
  endfunction
  task automatic cycle(input logic r, input logic s, input logic [7:0] irv);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n = r; step_en = s; ir = irv;
    e = micro(irv[7:4], mt);
    if (!r) e = idle(3'd0);
    else if (!s || mh) e = idle(e.bus);
    e.t = 3'(mt);
    e.halted = mh;
    q.push_back(e);
    if (!r) begin mt = 0; mh = 1'b0; end
    else if (s && !mh) begin
      if (mt == ilen(irv[7:4]) - 1) begin mt = 0; mh = (irv[7:4] == 4'hF); end
      else mt++;
    end
  endtask
  task automatic run_instr(input logic [7:0] irv);
    do cycle(1'b1, 1'b1, irv); while (mt != 0);
  endtask
  always @(negedge clk) begin
    exp_t a, e;
    if (q.size() > 0) begin
      e = q.pop_front();
      a = {bus_sel, ld_mar_n, ld_ir_n, ld_a_n, ld_b_n, ld_out_n, ram_we_n,
           pc_inc, pc_load, alu_sub, halted, instr_done, tstep};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL outputs @%0t ir=%h: got bus=%0d ld_n(mar,ir,a,b,out,we)=%b%b%b%b%b%b inc=%b ld=%b sub=%b h=%b done=%b t=%0d; want %h (got %h)",
                 $time, ir, bus_sel, ld_mar_n, ld_ir_n, ld_a_n, ld_b_n, ld_out_n, ram_we_n,
                 pc_inc, pc_load, alu_sub, halted, instr_done, tstep, e, a);
      end
    end
  end
  initial begin
    logic [7:0] cur;
    repeat (3) cycle(1'b0, 1'b1, 8'h00);
    run_instr(8'h53);
    run_instr(8'h70);
    run_instr(8'h2E);
    run_instr(8'h3E);
    run_instr(8'h4A);
    run_instr(8'h65);
    run_instr(8'h92);
    repeat (3) cycle(1'b1, 1'b1, 8'h2E);
    repeat (4) cycle(1'b1, 1'b0, 8'h2E);
    repeat (2) cycle(1'b1, 1'b1, 8'h2E);
    run_instr(8'hF0);
    repeat (10) cycle(1'b1, 1'($urandom_range(0, 1)), 8'hF0);
    cycle(1'b0, 1'b1, 8'h00);
    repeat (3) cycle(1'b1, 1'b1, 8'h1A);
    cycle(1'b0, 1'b1, 8'h1A);
    run_instr(8'h53);
    cur = 8'($urandom);
    repeat (1500) begin
      if (mt == 0) cur = 8'($urandom);
      cycle(1'($urandom_range(0, 99) >= 2), 1'($urandom_range(0, 99) < 80), cur);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, want 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
